// File: rtl/correction_frame_sequencer_if.sv
// Bus between the frame sequencer, the pixel source and the correction datapath.
// master: the sequencer side; slave: the source/datapath/controller side.
interface correction_frame_sequencer_if;
  logic        start;
  logic        abort;
  logic        src_valid;
  logic        src_ready;
  logic        dInValid;
  logic        dOuten;
  logic        dOutValid;
  logic [10:0] in_x;
  logic [10:0] in_y;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, abort, src_valid, dOutValid,
    output src_ready, dInValid, dOuten, in_x, in_y, busy, done, err
  );

  modport slave (
    output start, abort, src_valid, dOutValid,
    input  src_ready, dInValid, dOuten, in_x, in_y, busy, done, err
  );
endinterface

// File: rtl/correction_frame_sequencer.sv
// Sequences one correction frame: load input pixels (raster order), wait a
// fixed gap, then drain output pixels with a watchdog on the output strobe.
module correction_frame_sequencer #(
  parameter int IN_X_RES   = 693,
  parameter int IN_Y_RES   = 693,
  parameter int OUT_PIXELS = 141376,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  correction_frame_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_GAP   = 3'd2,
    S_DRAIN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [10:0] X_LAST   = 11'(IN_X_RES);
  localparam logic [10:0] Y_LAST   = 11'(IN_Y_RES);
  localparam logic [19:0] OUT_LAST = 20'(OUT_PIXELS - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [31:0] WD_LAST  = 32'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [10:0] r_in_x;
  logic [10:0] r_in_y;
  logic [19:0] r_out_cnt;
  logic [15:0] r_gap_cnt;
  logic [31:0] r_wd_cnt;
  logic        r_douten;
  logic        r_done;
  logic        r_err;

  logic        w_xfer;
  logic        w_last_pixel;
  logic        w_start_acc;
  logic        w_finish;
  logic        w_enter_err;

  assign w_xfer       = bus.src_valid && (r_state == S_LOAD);
  assign w_last_pixel = (r_in_x == X_LAST) && (r_in_y == Y_LAST);
  // Completion only counts when not overridden by abort in the same cycle.
  assign w_finish     = (r_state == S_DRAIN) && !bus.abort && bus.dOutValid &&
                        (r_out_cnt == OUT_LAST);
  assign w_enter_err  = (w_next_state == S_ERR) && (r_state != S_ERR);

  assign bus.src_ready = (r_state == S_LOAD);
  assign bus.dInValid  = w_xfer;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.dOuten    = r_douten;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.in_x      = r_in_x;
  assign bus.in_y      = r_in_y;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode; abort outranks every other transition.
  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          w_next_state = S_LOAD;
          w_start_acc  = 1'b1;
        end
      end
      S_LOAD: begin
        if (bus.abort)                  w_next_state = S_IDLE;
        else if (bus.dOutValid)         w_next_state = S_ERR;
        else if (w_xfer && w_last_pixel) w_next_state = S_GAP;
      end
      S_GAP: begin
        if (bus.abort)                   w_next_state = S_IDLE;
        else if (bus.dOutValid)          w_next_state = S_ERR;
        else if (r_gap_cnt == GAP_LAST)  w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.abort)                                   w_next_state = S_IDLE;
        else if (w_finish)                               w_next_state = S_IDLE;
        else if (!bus.dOutValid && (r_wd_cnt == WD_LAST)) w_next_state = S_ERR;
      end
      S_ERR: begin
        if (bus.abort) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Pixel position, gap/output/watchdog counters and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_x    <= '0;
      r_in_y    <= '0;
      r_out_cnt <= '0;
      r_gap_cnt <= '0;
      r_wd_cnt  <= '0;
      r_douten  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done   <= w_finish;
      r_douten <= (w_next_state == S_DRAIN);

      if (w_start_acc)      r_err <= 1'b0;
      else if (w_enter_err) r_err <= 1'b1;

      // Watchdog counts consecutive DRAIN cycles without an output strobe.
      if ((r_state != S_DRAIN) || bus.dOutValid) r_wd_cnt <= '0;
      else                                        r_wd_cnt <= r_wd_cnt + 32'd1;

      if (w_start_acc) begin
        r_in_x    <= '0;
        r_in_y    <= '0;
        r_out_cnt <= '0;
        r_gap_cnt <= '0;
      end else begin
        // The final transfer leaves LOAD, so position holds at its terminal value.
        if ((r_state == S_LOAD) && (w_next_state == S_LOAD) && w_xfer) begin
          if (r_in_x == X_LAST) begin
            r_in_x <= '0;
            r_in_y <= r_in_y + 11'd1;
          end else begin
            r_in_x <= r_in_x + 11'd1;
          end
        end

        if ((r_state == S_GAP) && (w_next_state == S_GAP))
          r_gap_cnt <= r_gap_cnt + 16'd1;
        else if ((r_state != S_GAP) && (w_next_state == S_GAP))
          r_gap_cnt <= '0;

        // The completing strobe leaves DRAIN, so the count stops at OUT_PIXELS.
        if ((r_state == S_DRAIN) && bus.dOutValid && !bus.abort)
          r_out_cnt <= r_out_cnt + 20'd1;
      end
    end
  end

endmodule

// File: doc/correction_frame_sequencer.md
CORRECTION_FRAME_SEQUENCER -- requirements
Module: correction_frame_sequencer

Interface
REQ-001 Parameter IN_X_RES, default 693, input width minus 1 (pixels per line - 1).
REQ-002 Parameter IN_Y_RES, default 693, input height minus 1 (lines - 1).
REQ-003 Parameter OUT_PIXELS, default 141376, output pixels per frame (376*376).
REQ-004 Parameter GAP_CYCLES, default 16, idle cycles between end of load and start of drain; legal range 1..65535.
REQ-005 Parameter TIMEOUT, default 4096, maximum cycles allowed between consecutive dOutValid pulses while draining.
REQ-006 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, one-cycle request to sequence one frame; ignored unless idle.
REQ-009 Port abort, input, 1, synchronous abort; returns to IDLE from any state.
REQ-010 Port src_valid, input, 1, upstream pixel available.
REQ-011 Port src_ready, output, 1, sequencer accepts a pixel this cycle.
REQ-012 Port dInValid, output, 1, pixel-valid strobe to the correction datapath.
REQ-013 Port dOuten, output, 1, output-phase enable to the correction datapath.
REQ-014 Port dOutValid, input, 1, output-pixel strobe from the correction datapath.
REQ-015 Port in_x, output, 11, column of the pixel accepted this cycle.
REQ-016 Port in_y, output, 11, line of the pixel accepted this cycle.
REQ-017 Port busy, output, 1, high in every state except IDLE.
REQ-018 Port done, output, 1, one-cycle pulse on frame completion.
REQ-019 Port err, output, 1, sticky error flag; cleared only by reset or the next accepted start.

Function
REQ-020 States SHALL be IDLE, LOAD, GAP, DRAIN, ERR; encoding is free.
REQ-021 IDLE -> LOAD on start; in_x, in_y, output count and gap counter SHALL be zeroed on that edge.
REQ-022 In LOAD, src_ready SHALL be 1; a transfer occurs when src_valid && src_ready; dInValid SHALL equal src_valid && state==LOAD (combinational).
REQ-023 Per transfer, in_x SHALL increment; when in_x==IN_X_RES it SHALL wrap to 0 and in_y SHALL increment.
REQ-024 A transfer with in_x==IN_X_RES and in_y==IN_Y_RES SHALL move LOAD -> GAP on the same edge; src_ready SHALL be 0 from the next cycle.
REQ-025 GAP SHALL last exactly GAP_CYCLES cycles, then move to DRAIN.
REQ-026 In DRAIN, dOuten SHALL be 1 (registered; high on the first DRAIN cycle); it SHALL be 0 in all other states.
REQ-027 In DRAIN, each cycle with dOutValid==1 SHALL increment a 20-bit output counter; the pulse taking it to OUT_PIXELS SHALL move DRAIN -> IDLE and assert done for exactly one cycle on the next cycle.
REQ-028 In DRAIN, a watchdog SHALL reset on every dOutValid and, after TIMEOUT consecutive cycles without it, move to ERR and set err.
REQ-029 dOutValid asserted in LOAD or GAP SHALL set err and move to ERR; in IDLE it SHALL be ignored.
REQ-030 ERR SHALL hold src_ready=0, dOuten=0, busy=1 until abort, then move to IDLE; start is ignored in ERR.
REQ-031 abort SHALL take priority over every other transition and SHALL not pulse done; abort in IDLE has no effect.
REQ-032 start while busy SHALL be ignored with no state or counter change.
REQ-033 Simultaneous final input transfer and abort: abort wins, state IDLE, no GAP entry.
REQ-034 Counters SHALL not wrap past terminal values; in_x/in_y hold while no transfer occurs.

Reset
REQ-035 While rst_n==0: state IDLE; src_ready, dInValid, dOuten, busy, done, err = 0; in_x, in_y, all counters = 0.
REQ-036 Reset deassertion SHALL take effect at the next clk edge; reset mid-frame abandons the frame with no done pulse.

Verification
REQ-037 IN 3x2 (params 2,1), OUT_PIXELS 4, GAP 2, continuous src_valid: 6 transfers, in_x sequence 0,1,2,0,1,2, in_y 0,0,0,1,1,1; dOuten rises 2 cycles after last transfer; 4 dOutValid -> done one cycle, busy low.
REQ-038 src_valid toggling 1/0 in LOAD: only 6 transfers counted, dInValid low on gap cycles, in_x/in_y hold.
REQ-039 DRAIN, dOutValid withheld TIMEOUT(=8) cycles -> err=1 and ERR; abort -> IDLE; next start clears err.
REQ-040 dOutValid pulse during GAP -> err=1, ERR, dOuten stays 0.
REQ-041 abort on cycle of final input transfer -> IDLE, no dOuten, no done; start pulse during LOAD ignored.
REQ-042 rst_n low mid-DRAIN -> all outputs 0 immediately (asynchronous); after release, start begins a new frame from in_x=0, in_y=0.
